inst_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the sequencer instruction ROM.

---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_fetch_if.sv | 43 ++++
 rtl/inst_fbuf.sv | 79 +++++++
 rtl/inst_fetch.sv | 148 ++++++++++++++
 tb/tb_inst_fetch.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int unsigned IF_DWIDTH     = 32;   // instruction word width
  localparam int unsigned IF_DEPTH      = 256;  // ROM depth / PC space
  localparam int unsigned IF_BRAM_DELAY = 2;    // ROM read latency

  // Fetch controller states
  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_DRAIN = 2'd2,
    IF_DONE  = 2'd3
  } if_state_e;

  // Buffer entries required to sustain one word per cycle through the ROM latency
  function automatic int unsigned fbuf_entries(input int unsigned bram_delay);
    return bram_delay + 2;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Control, ROM and decoder signals of the fetch stage.
// slave: the fetch stage itself; master: controller / ROM / decoder side.
interface inst_fetch_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 8
);
  // VP controller
  logic              start;
  logic [AWIDTH-1:0] start_pc;
  logic [AWIDTH-1:0] end_pc;
  logic              redirect;
  logic [AWIDTH-1:0] redirect_pc;
  logic              busy;
  logic              done;
  // Instruction ROM
  logic              rom_rden;
  logic [AWIDTH-1:0] rom_addr;
  logic              rom_vld;
  logic [DWIDTH-1:0] rom_dout;
  // Decoder
  logic              inst_vld;
  logic              inst_rdy;
  logic [DWIDTH-1:0] inst_data;

  modport slave (
    input  start, start_pc, end_pc, redirect, redirect_pc,
    output busy, done,
    output rom_rden, rom_addr,
    input  rom_vld, rom_dout,
    output inst_vld, inst_data,
    input  inst_rdy
  );

  modport master (
    output start, start_pc, end_pc, redirect, redirect_pc,
    input  busy, done,
    input  rom_rden, rom_addr,
    output rom_vld, rom_dout,
    input  inst_vld, inst_data,
    output inst_rdy
  );

endinterface

// File: rtl/inst_fbuf.sv
// Fetch buffer: synchronous FIFO with flush, occupancy count and a read port
// driven from registered pointers. Output word is forced to zero when empty.
module inst_fbuf #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic              vld,
  output logic [DWIDTH-1:0] dout,
  output logic [CW-1:0]     cnt
);

  localparam int unsigned        PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]      PTR_MAX = PW'(DEPTH - 1);
  localparam logic [CW-1:0]      CNT_MAX = CW'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt_q;
  logic              do_push;
  logic              do_pop;

  // Qualify push/pop; flush overrides both
  always_comb begin
    do_push = push && !flush;
    do_pop  = pop && !flush && (cnt_q != '0);
  end

  // Storage needs no reset: empty entries are never presented
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Head word presented to the consumer
  always_comb begin
    vld  = (cnt_q != '0);
    dout = vld ? mem[rd_ptr] : '0;
    cnt  = cnt_q;
  end

  // Upstream credit accounting must never let a write land on a full buffer
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && (cnt_q == CNT_MAX)));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: walks PC from start_pc to end_pc issuing ROM reads,
// captures returns into a credit-protected buffer and hands words to the
// decoder over valid/ready. Redirect flushes and resumes at a new PC.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DWIDTH            = IF_DWIDTH,
  parameter int unsigned DEPTH             = IF_DEPTH,
  parameter int unsigned AWIDTH            = $clog2(DEPTH),
  parameter int unsigned COMMON_BRAM_DELAY = IF_BRAM_DELAY,
  parameter int unsigned FBUF_DEPTH        = fbuf_entries(COMMON_BRAM_DELAY)
) (
  input  logic       clk,
  input  logic       rst_n,
  inst_fetch_if.slave bus
);

  localparam int unsigned   CW      = $clog2(FBUF_DEPTH + 1);
  localparam logic [AWIDTH-1:0] PC_LAST = AWIDTH'(DEPTH - 1);
  localparam logic [CW:0]   CREDITS = (CW + 1)'(FBUF_DEPTH);

  if_state_e         state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] end_q, end_d;
  logic [CW-1:0]     infl_q, infl_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic [CW-1:0]     fbuf_cnt;
  logic              fbuf_vld;
  logic [DWIDTH-1:0] fbuf_dout;
  logic [CW:0]       occ;
  logic              rv;
  logic              redir;
  logic              issue;
  logic              push;
  logic              pop;

  // Issue / capture qualification. A ROM return only counts while reads are
  // outstanding, so stale returns after reset are ignored.
  always_comb begin
    occ   = {1'b0, infl_q} + {1'b0, fbuf_cnt};
    rv    = bus.rom_vld && (infl_q != '0);
    redir = bus.redirect && ((state_q == IF_FETCH) || (state_q == IF_DRAIN));
    issue = (state_q == IF_FETCH) && !redir && (occ < CREDITS);
    push  = rv && (drop_q == '0) && !redir;
    pop   = fbuf_vld && bus.inst_rdy;
  end

  // Next state, PC and counters
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    end_d   = end_q;
    infl_d  = infl_q + CW'(issue) - CW'(rv);
    drop_d  = drop_q;

    case (state_q)
      IF_IDLE: begin
        if (bus.start) begin
          state_d = IF_FETCH;
          pc_d    = bus.start_pc;
          end_d   = bus.end_pc;
        end
      end
      IF_FETCH: begin
        if (issue && (pc_q == end_q)) begin
          state_d = IF_DRAIN;
        end
      end
      IF_DRAIN: begin
        if ((infl_q == '0) && (fbuf_cnt == '0) && (drop_q == '0)) begin
          state_d = IF_DONE;
        end
      end
      IF_DONE: begin
        state_d = IF_IDLE;
      end
      default: begin
        state_d = IF_IDLE;
      end
    endcase

    if (issue) begin
      pc_d = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
    end

    if (rv && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end

    // Every read still outstanding after this cycle's return becomes a drop
    if (redir) begin
      state_d = IF_FETCH;
      pc_d    = bus.redirect_pc;
      drop_d  = infl_q - CW'(rv);
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF_IDLE;
      pc_q    <= '0;
      end_q   <= '0;
      infl_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      end_q   <= end_d;
      infl_q  <= infl_d;
      drop_q  <= drop_d;
    end
  end

  inst_fbuf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FBUF_DEPTH),
    .CW     (CW)
  ) u_fbuf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redir),
    .push  (push),
    .din   (bus.rom_dout),
    .pop   (pop),
    .vld   (fbuf_vld),
    .dout  (fbuf_dout),
    .cnt   (fbuf_cnt)
  );

  // Outputs to ROM, decoder and controller
  always_comb begin
    bus.rom_rden  = issue;
    bus.rom_addr  = issue ? pc_q : '0;
    bus.inst_vld  = fbuf_vld;
    bus.inst_data = fbuf_dout;
    bus.busy      = (state_q == IF_FETCH) || (state_q == IF_DRAIN);
    bus.done      = (state_q == IF_DONE);
  end

  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    occ <= CREDITS);

  a_drop_le_infl: assert property (@(posedge clk) disable iff (!rst_n)
    drop_q <= infl_q);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a latency-accurate ROM model and a
// scoreboard of expected instruction words.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned D     = 2;
  localparam int          FB    = D + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  inst_fetch #(
    .DWIDTH            (DW),
    .DEPTH             (DEPTH),
    .AWIDTH            (AW),
    .COMMON_BRAM_DELAY (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] rom_word(input int unsigned a);
    return 32'h5A00_0000 ^ (a * 32'h0001_0203);
  endfunction

  // ROM: D-cycle read pipeline, deliberately not reset
  logic [D-1:0]  pv = '0;
  logic [AW-1:0] pa [D] = '{default: '0};
  always @(posedge clk) begin
    pv[0] <= bus.rom_rden;
    pa[0] <= bus.rom_addr;
    for (int i = 1; i < D; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign bus.rom_vld  = pv[D-1];
  assign bus.rom_dout = rom_word(int'(pa[D-1]));

  int n_chk = 0;
  int n_fail = 0;
  int n_iss = 0;
  int n_xfer = 0;
  int n_done = 0;
  int max_occ = 0;
  bit occ_watch = 1'b0;
  logic [DW-1:0] exp_q [$];

  // Monitor: scoreboard pop on every transfer, issue/done counting, credit watch
  always @(negedge clk) begin
    int occ;
    logic [DW-1:0] exp_w;
    if (rst_n) begin
      occ = n_iss + (bus.rom_rden ? 1 : 0) - n_xfer;
      if (occ_watch) begin
        if (occ > max_occ) max_occ = occ;
        n_chk++;
        assert (occ <= FB) else begin
          n_fail++;
          $error("FAIL credit_occupancy observed=%0d required<=%0d", occ, FB);
        end
      end
      if (bus.rom_rden) n_iss++;
      if (bus.done) n_done++;
      if (bus.inst_vld && bus.inst_rdy) begin
        n_xfer++;
        n_chk++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected observed=%h required=no_word", bus.inst_data);
        end
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          n_chk++;
          assert (bus.inst_data === exp_w) else begin
            n_fail++;
            $error("FAIL sb_data observed=%h required=%h", bus.inst_data, exp_w);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [AW-1:0] a;
    a = s;
    forever begin
      exp_q.push_back(rom_word(int'(a)));
      if (a == e) break;
      a = a + 1'b1;
    end
  endtask

  // Pulse start for one cycle; returns positioned in the first FETCH cycle
  task automatic start_run(input logic [AW-1:0] s, input logic [AW-1:0] e);
    n_iss = 0;
    n_xfer = 0;
    n_done = 0;
    max_occ = 0;
    push_range(s, e);
    bus.start    = 1'b1;
    bus.start_pc = s;
    bus.end_pc   = e;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = bus.done;
    end
    n_chk++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL %s_done_timeout observed=none required=done_within_%0d", tag, budget);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=no_finish required=finish_before_100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int xfer_before;
    logic [DW-1:0] held;

    bus.start = 1'b0;  bus.start_pc = '0;  bus.end_pc = '0;
    bus.redirect = 1'b0;  bus.redirect_pc = '0;  bus.inst_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rden", bus.rom_rden, 0);
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_inst_vld", bus.inst_vld, 0);
    chk("rst_inst_data", bus.inst_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // 1: 0..7 full rate, latency and back-to-back delivery
    start_run(8'h00, 8'h07);
    @(negedge clk);
    chk("t1_first_rden", bus.rom_rden, 1);
    chk("t1_first_addr", bus.rom_addr, 0);
    chk("t1_busy", bus.busy, 1);
    for (int c = 1; c <= int'(D); c++) begin
      @(negedge clk);
      chk("t1_vld_early", bus.inst_vld, 0);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t1_vld_b2b", bus.inst_vld, 1);
    end
    wait_done(5, "t1");
    tick();
    chk("t1_done_once", n_done, 1);
    chk("t1_xfers", n_xfer, 8);
    chk("t1_issues", n_iss, 8);
    chk("t1_sb_empty", exp_q.size(), 0);
    chk("t1_busy_after", bus.busy, 0);

    // 2: decoder stall mid-stream
    start_run(8'h00, 8'd31);
    repeat (6) tick();
    bus.inst_rdy = 1'b0;
    occ_watch = 1'b1;
    @(negedge clk);
    held = bus.inst_data;
    chk("t2_vld_at_stall", bus.inst_vld, 1);
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      chk("t2_hold_vld", bus.inst_vld, 1);
      chk("t2_hold_data", bus.inst_data, held);
    end
    @(posedge clk); #1;
    bus.inst_rdy = 1'b1;
    occ_watch = 1'b0;
    chk("t2_credits_filled", max_occ, FB);
    wait_done(80, "t2");
    chk("t2_xfers", n_xfer, 32);
    chk("t2_sb_empty", exp_q.size(), 0);

    // 3: PC wrap across the top of the address space
    start_run(AW'(DEPTH - 2), 8'h01);
    wait_done(30, "t3");
    chk("t3_issues", n_iss, 4);
    chk("t3_xfers", n_xfer, 4);
    chk("t3_sb_empty", exp_q.size(), 0);

    // 4: redirect with reads in flight
    start_run(8'h10, 8'h27);
    repeat (5) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 8'h20;
    bus.inst_rdy = 1'b0;
    @(negedge clk);
    chk("t4_inflight_at_redirect", $countones(pv), D);
    chk("t4_no_issue_redirect", bus.rom_rden, 0);
    exp_q.delete();
    push_range(8'h20, 8'h27);
    xfer_before = n_xfer;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    bus.inst_rdy = 1'b1;
    wait_done(40, "t4");
    chk("t4_xfers_after", n_xfer - xfer_before, 8);
    chk("t4_sb_empty", exp_q.size(), 0);

    // 5: single word; start while busy ignored
    start_run(8'h05, 8'h05);
    bus.start = 1'b1;
    bus.start_pc = 8'h09;
    bus.end_pc = 8'h0C;
    tick();
    bus.start = 1'b0;
    wait_done(20, "t5");
    repeat (4) tick();
    chk("t5_issues", n_iss, 1);
    chk("t5_xfers", n_xfer, 1);
    chk("t5_done_once", n_done, 1);
    chk("t5_busy_after", bus.busy, 0);
    chk("t5_sb_empty", exp_q.size(), 0);

    // 6: reset during DRAIN with reads outstanding
    start_run(8'h30, 8'h33);
    repeat (4) tick();
    chk("t6_read_in_flight", pv[0], 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rden", bus.rom_rden, 0);
    chk("t6_rst_addr", bus.rom_addr, 0);
    chk("t6_rst_inst_vld", bus.inst_vld, 0);
    chk("t6_rst_inst_data", bus.inst_data, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_done", bus.done, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_late_vld_a", bus.inst_vld, 0);
    @(negedge clk);
    chk("t6_late_vld_b", bus.inst_vld, 0);
    repeat (3) tick();
    start_run(8'h40, 8'h45);
    wait_done(30, "t6");
    chk("t6_xfers", n_xfer, 6);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
